// File: rtl/output_requant_fifo.sv
// Requantizes signed MAC accumulator words (round, shift, saturate) and buffers
// them with their output coordinates in a small FIFO toward the result writer.
module output_requant_fifo #(
  parameter int ACC_WIDTH    = 32,
  parameter int OUT_WIDTH    = 16,
  parameter int OUTPUT_SCALE = 0,
  parameter int FIFO_DEPTH   = 4,
  parameter int X_WIDTH      = 10,
  parameter int Y_WIDTH      = 10,
  parameter int CH_WIDTH     = 6
) (
  input  logic                          clk,
  input  logic                          arst_n_in,
  input  logic                          in_valid,
  input  logic [ACC_WIDTH-1:0]          in_data,
  input  logic [X_WIDTH-1:0]            in_x,
  input  logic [Y_WIDTH-1:0]            in_y,
  input  logic [CH_WIDTH-1:0]           in_ch,
  input  logic                          clear,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic [X_WIDTH-1:0]            out_x,
  output logic [Y_WIDTH-1:0]            out_y,
  output logic [CH_WIDTH-1:0]           out_ch,
  output logic                          out_sat,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RND_SH = (OUTPUT_SCALE > 0) ? OUTPUT_SCALE - 1 : 0;
  localparam logic signed [ACC_WIDTH:0] RND =
    (OUTPUT_SCALE > 0) ? ((ACC_WIDTH+1)'(1) << RND_SH) : '0;
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // One extra bit keeps the rounding add from wrapping at the positive rail.
  logic signed [ACC_WIDTH:0] w_sum;
  logic signed [ACC_WIDTH:0] w_shift;
  logic [OUT_WIDTH-1:0]      w_q;
  logic                      w_sat;

  always_comb begin
    w_sum   = $signed({in_data[ACC_WIDTH-1], in_data}) + RND;
    w_shift = w_sum >>> OUTPUT_SCALE;
    w_q     = w_shift[OUT_WIDTH-1:0];
    w_sat   = 1'b0;
    if (w_shift > SAT_MAX) begin
      w_q   = SAT_MAX[OUT_WIDTH-1:0];
      w_sat = 1'b1;
    end else if (w_shift < SAT_MIN) begin
      w_q   = SAT_MIN[OUT_WIDTH-1:0];
      w_sat = 1'b1;
    end
  end

  logic [OUT_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic                 r_mem_sat  [FIFO_DEPTH];
  logic [X_WIDTH-1:0]   r_mem_x    [FIFO_DEPTH];
  logic [Y_WIDTH-1:0]   r_mem_y    [FIFO_DEPTH];
  logic [CH_WIDTH-1:0]  r_mem_ch   [FIFO_DEPTH];

  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_level;
  logic          r_overflow;
  logic          w_full, w_pop, w_push;

  assign w_full = (r_level == (AW+1)'(FIFO_DEPTH));
  assign w_pop  = out_valid && out_ready;
  assign w_push = in_valid && (!w_full || w_pop);

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (in_valid && !w_push) r_overflow <= 1'b1;
    end
  end

  // Storage is deliberately unreset; validity lives entirely in the pointers.
  always_ff @(posedge clk) begin
    if (w_push && !clear) begin
      r_mem_data[r_wptr] <= w_q;
      r_mem_sat[r_wptr]  <= w_sat;
      r_mem_x[r_wptr]    <= in_x;
      r_mem_y[r_wptr]    <= in_y;
      r_mem_ch[r_wptr]   <= in_ch;
    end
  end

  assign out_valid = (r_level != '0);
  assign out_data  = r_mem_data[r_rptr];
  assign out_sat   = r_mem_sat[r_rptr];
  assign out_x     = r_mem_x[r_rptr];
  assign out_y     = r_mem_y[r_rptr];
  assign out_ch    = r_mem_ch[r_rptr];
  assign level     = r_level;
  assign overflow  = r_overflow;
endmodule

// File: tb/tb_output_requant_fifo.sv
// Directed bench: two instances (scale 0 and scale 4) share stimulus; outputs
// are checked against hand-computed values one time unit after each rising edge.
module tb_output_requant_fifo;
  logic        clk = 1'b0;
  logic        arst_n_in;
  logic        in_valid, clear, out_ready;
  logic [31:0] in_data;
  logic [9:0]  in_x, in_y;
  logic [5:0]  in_ch;

  logic        v0, s0, o0, v4, s4, o4;
  logic [15:0] d0, d4;
  logic [9:0]  x0, y0, x4, y4;
  logic [5:0]  c0, c4;
  logic [2:0]  l0, l4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  output_requant_fifo #(.OUTPUT_SCALE(0)) u_dut (
    .clk(clk), .arst_n_in(arst_n_in), .in_valid(in_valid), .in_data(in_data),
    .in_x(in_x), .in_y(in_y), .in_ch(in_ch), .clear(clear),
    .out_valid(v0), .out_ready(out_ready), .out_data(d0), .out_x(x0),
    .out_y(y0), .out_ch(c0), .out_sat(s0), .level(l0), .overflow(o0));

  output_requant_fifo #(.OUTPUT_SCALE(4)) u_s4 (
    .clk(clk), .arst_n_in(arst_n_in), .in_valid(in_valid), .in_data(in_data),
    .in_x(in_x), .in_y(in_y), .in_ch(in_ch), .clear(clear),
    .out_valid(v4), .out_ready(out_ready), .out_data(d4), .out_x(x4),
    .out_y(y4), .out_ch(c4), .out_sat(s4), .level(l4), .overflow(o4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    arst_n_in = 1'b0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
    in_data = '0; in_x = '0; in_y = '0; in_ch = '0;
    #12;
    chk("rst_level", 32'(l0), 0);
    chk("rst_valid", 32'(v0), 0);
    chk("rst_ovf",   32'(o0), 0);
    chk("rst_valid4", 32'(v4), 0);
    @(negedge clk);
    arst_n_in = 1'b1;
    tick();

    // rounding: (296+8)>>4 = 19; latency one edge
    out_ready = 1'b1; in_x = 10'd5; in_y = 10'd6; in_ch = 6'd7;
    push(32'd296);
    chk("s4_valid", 32'(v4), 1);
    chk("s4_data",  32'(d4), 19);
    chk("s4_sat",   32'(s4), 0);
    chk("s0_data",  32'(d0), 296);
    chk("coord_x",  32'(x4), 5);
    chk("coord_y",  32'(y4), 6);
    chk("coord_ch", 32'(c4), 7);
    tick();
    chk("pop_empty", 32'(l4), 0);

    // negative rounding: (-296+8)>>>4 = -18
    out_ready = 1'b0;
    push(-32'sd296);
    chk("s4_neg", 32'(d4), 32'(16'hFFEE));
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // saturation and the exact positive rail
    push(32'd40000);
    push(-32'sd40000);
    push(32'd32767);
    chk("sat_level", 32'(l0), 3);
    chk("sat_pos",   32'(d0), 32767);
    chk("sat_pos_f", 32'(s0), 1);
    out_ready = 1'b1; tick();
    chk("sat_neg",   32'(d0), 32'(16'h8000));
    chk("sat_neg_f", 32'(s0), 1);
    tick();
    chk("rail_data", 32'(d0), 32767);
    chk("rail_sat",  32'(s0), 0);
    tick();
    chk("sat_empty", 32'(v0), 0);
    out_ready = 1'b0;

    // full + overflow: 1..5 pushed, 5 dropped
    for (int i = 1; i <= 5; i++) push(32'(i));
    chk("full_level", 32'(l0), 4);
    chk("full_ovf",   32'(o0), 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("drain%0d", i), 32'(d0), 32'(i));
      tick();
    end
    chk("drain_empty", 32'(v0), 0);
    chk("ovf_sticky",  32'(o0), 1);
    out_ready = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_ovf", 32'(o0), 0);

    // full with simultaneous pop
    for (int i = 10; i <= 13; i++) push(32'(i));
    chk("fp_level0", 32'(l0), 4);
    out_ready = 1'b1;
    push(32'd14);
    chk("fp_level", 32'(l0), 4);
    chk("fp_ovf",   32'(o0), 0);
    for (int i = 11; i <= 14; i++) begin
      chk($sformatf("fp_drain%0d", i), 32'(d0), 32'(i));
      tick();
    end
    chk("fp_empty", 32'(l0), 0);
    out_ready = 1'b0;

    // clear beats same-cycle push and pop
    for (int i = 1; i <= 5; i++) push(32'(i));
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("cp_level", 32'(l0), 3);
    chk("cp_ovf",   32'(o0), 1);
    clear = 1'b1; out_ready = 1'b1;
    push(32'd9);
    clear = 1'b0; out_ready = 1'b0;
    chk("cp_level0", 32'(l0), 0);
    chk("cp_valid",  32'(v0), 0);
    chk("cp_ovf0",   32'(o0), 0);

    // asynchronous reset mid-stream
    push(32'd1);
    push(32'd2);
    chk("ar_level", 32'(l0), 2);
    #2 arst_n_in = 1'b0;
    #1;
    chk("ar_valid", 32'(v0), 0);
    chk("ar_level0", 32'(l0), 0);
    @(negedge clk);
    arst_n_in = 1'b1;
    tick();
    chk("ar_empty", 32'(v0), 0);
    push(32'd7);
    chk("ar_data",  32'(d0), 7);
    chk("ar_lvl1",  32'(l0), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/output_requant_fifo.md
OUTPUT_REQUANT_FIFO -- requirements
Module: output_requant_fifo

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 32, width of the accumulator word from the MAC.
REQ-002 SHALL have parameter OUT_WIDTH, default 16, width of the requantized output word.
REQ-003 SHALL have parameter OUTPUT_SCALE, default 0, arithmetic right-shift amount; legal range 0..ACC_WIDTH-1.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, number of entries; power of two, at least 2.
REQ-005 SHALL have parameters X_WIDTH, default 10; Y_WIDTH, default 10; CH_WIDTH, default 6; coordinate widths.
REQ-006 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port arst_n_in, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port in_valid, input, 1, accumulator word present this cycle; there is no backpressure to the producer.
REQ-009 SHALL have port in_data, input, ACC_WIDTH, signed accumulator value.
REQ-010 SHALL have ports in_x, in_y and in_ch, inputs, of widths X_WIDTH, Y_WIDTH and CH_WIDTH, carrying the output coordinates.
REQ-011 SHALL have port clear, input, 1, synchronous flush of the FIFO and the sticky flags.
REQ-012 SHALL have port out_valid, output, 1, head entry available.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts the head entry.
REQ-014 SHALL have port out_data, output, OUT_WIDTH, signed requantized head value.
REQ-015 SHALL have ports out_x, out_y and out_ch, outputs, carrying the head entry coordinates.
REQ-016 SHALL have port out_sat, output, 1, head value was saturated.
REQ-017 SHALL have port level, output, $clog2(FIFO_DEPTH)+1, current occupancy.
REQ-018 SHALL have port overflow, output, 1, sticky flag: a word was dropped.

Function
REQ-019 SHALL requantize combinationally on the input side in three steps:
- if OUTPUT_SCALE>0, add 2^(OUTPUT_SCALE-1) in ACC_WIDTH+1 bits;
- arithmetic right shift by OUTPUT_SCALE;
- saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-020 SHALL set the stored sat bit when saturation changed the value, and clear it otherwise.
REQ-021 SHALL define push as in_valid and (not full, or pop in the same cycle), where pop is out_valid and out_ready.
REQ-022 SHALL write the pushed entry {data, sat, x, y, ch} at the tail on the clock edge and advance the tail pointer modulo FIFO_DEPTH.
REQ-023 SHALL, on pop, advance the head pointer modulo FIFO_DEPTH on the clock edge.
REQ-024 SHALL drive out_valid = (level != 0), and drive the out_* data ports from the head entry.
REQ-025 SHALL have latency 1: a word pushed into an empty FIFO at edge N shall appear with out_valid=1 in the cycle after edge N.
REQ-026 SHALL keep the head entry stable while out_valid=1 and out_ready=0.
REQ-027 SHALL update level by +1 on push only, -1 on pop only, and 0 on push and pop together.
REQ-028 SHALL, when full with in_valid=1 and no pop, drop the word, leave FIFO contents unchanged, and set overflow.
REQ-029 SHALL, when full with in_valid=1 and pop in the same cycle, accept the word with no overflow.
REQ-030 SHALL, when empty, ignore out_ready and neither pop nor underflow.
REQ-031 SHALL, when clear=1, on that edge set level to 0, set both pointers to 0, clear overflow, and ignore any same-cycle push or pop.
REQ-032 SHALL keep out_data, out_x, out_y, out_ch and out_sat stable, with value don't-care, while out_valid=0.

Reset
REQ-033 SHALL, while arst_n_in=0, asynchronously force level=0, out_valid=0, overflow=0, and both pointers to 0.
REQ-034 SHALL leave the data storage unreset; the out_* data ports are don't-care while out_valid=0.
REQ-035 SHALL, on reset assertion mid-operation, discard all stored entries; after release the block shall behave as empty.

Verification
REQ-036 SHALL cover scale with rounding and no saturation: OUTPUT_SCALE=4, push in_data=0x00000128 (296), out_ready=1 -> next cycle out_valid=1, out_data=19, out_sat=0.
REQ-037 SHALL cover saturation: OUTPUT_SCALE=0, push 40000, then -40000 -> out_data=32767 with sat=1, then -32768 with sat=1, in order.
REQ-038 SHALL cover full and overflow: FIFO_DEPTH=4, out_ready=0, 5 consecutive pushes with data 1..5 -> level=4, overflow=1; draining yields exactly 1,2,3,4.
REQ-039 SHALL cover full with simultaneous pop: level=4, in_valid=1 and out_ready=1 in the same cycle -> level stays 4, overflow stays 0, new word is read last.
REQ-040 SHALL cover clear priority: level=3 and overflow=1, then clear=1 with in_valid=1 -> next cycle level=0, out_valid=0, overflow=0.
REQ-041 SHALL cover reset mid-stream: level=2, arst_n_in pulsed low -> out_valid=0 immediately; after release a push of 7 reads back as 7.
